// File: rtl/mem_arbiter_if.sv
// Bus bundle between the three cache-side requesters, the memory port and
// the mem_arbiter. The slave modport is the arbiter's view; the master
// modport is the view of whatever drives requests and memory replies.
interface mem_arbiter_if;
  logic [1:0]  d_command;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [1:0]  i_command;
  logic [63:0] i_addr;
  logic [1:0]  p_command;
  logic [63:0] p_addr;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  d_response;
  logic [3:0]  i_response;
  logic [3:0]  p_response;
  logic [3:0]  d_tag;
  logic [3:0]  i_tag;
  logic [3:0]  p_tag;
  logic [63:0] rdata;
  logic [4:0]  outstanding;
  logic        tag_err;

  modport slave (
    input  d_command, d_addr, d_wdata, i_command, i_addr, p_command, p_addr,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output d_response, i_response, p_response, d_tag, i_tag, p_tag,
    output rdata, outstanding, tag_err
  );

  modport master (
    output d_command, d_addr, d_wdata, i_command, i_addr, p_command, p_addr,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  d_response, i_response, p_response, d_tag, i_tag, p_tag,
    input  rdata, outstanding, tag_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Three-way memory arbiter (Dcache, Icache, prefetcher) sharing one memory
// port. Grants are combinational; accepted loads are remembered in a
// 16-entry tag-indexed owner table so completions can be steered back.
// Optional feature: define MEM_ARB_RR_EN for rotating (round-robin)
// priority; otherwise priority is fixed D > I > P.
module mem_arbiter (
  input logic        clock,
  input logic        reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [1:0] {
    OWN_D = 2'd0,
    OWN_I = 2'd1,
    OWN_P = 2'd2
  } owner_e;

  logic        grant_valid;
  owner_e      grant_owner;
  logic [2:0]  req_vec;

  logic [15:0] entry_valid;
  owner_e      entry_owner [16];

  logic        alloc_en;
  logic        comp_hit;
  logic        comp_miss;
  logic        count_inc;

  // Eligibility vector, indexed by owner code
  always_comb begin
    req_vec = {bus.p_command != BUS_NONE,
               bus.i_command != BUS_NONE,
               bus.d_command != BUS_NONE};
  end

`ifdef MEM_ARB_RR_EN
  owner_e rr_ptr;

  function automatic owner_e next_owner(input owner_e o);
    case (o)
      OWN_D:   return OWN_I;
      OWN_I:   return OWN_P;
      default: return OWN_D;
    endcase
  endfunction

  // Pick the first eligible requester starting from the rotating pointer
  always_comb begin
    owner_e cand;
    grant_valid = 1'b0;
    grant_owner = OWN_D;
    cand        = rr_ptr;
    for (int k = 0; k < 3; k++) begin
      if (!grant_valid && req_vec[cand]) begin
        grant_valid = 1'b1;
        grant_owner = cand;
      end
      cand = next_owner(cand);
    end
  end

  // Advance the pointer past the winner only when memory accepted the grant
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= OWN_D;
    end else if (grant_valid && bus.mem2proc_response != 4'd0) begin
      rr_ptr <= next_owner(grant_owner);
    end
  end
`else
  // Fixed priority: D beats I beats P
  always_comb begin
    grant_valid = |req_vec;
    if (req_vec[0])      grant_owner = OWN_D;
    else if (req_vec[1]) grant_owner = OWN_I;
    else                 grant_owner = OWN_P;
  end
`endif

  // Steer the winner onto the memory port and route the accept tag back
  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = 64'd0;
    bus.proc2mem_data    = 64'd0;
    bus.d_response       = 4'd0;
    bus.i_response       = 4'd0;
    bus.p_response       = 4'd0;
    if (grant_valid) begin
      case (grant_owner)
        OWN_D: begin
          bus.proc2mem_command = bus.d_command;
          bus.proc2mem_addr    = bus.d_addr;
          bus.proc2mem_data    = bus.d_wdata;
          bus.d_response       = bus.mem2proc_response;
        end
        OWN_I: begin
          bus.proc2mem_command = bus.i_command;
          bus.proc2mem_addr    = bus.i_addr;
          bus.i_response       = bus.mem2proc_response;
        end
        default: begin
          bus.proc2mem_command = bus.p_command;
          bus.proc2mem_addr    = bus.p_addr;
          bus.p_response       = bus.mem2proc_response;
        end
      endcase
    end
  end

  // Decode table events for this cycle
  always_comb begin
    alloc_en  = grant_valid && (bus.proc2mem_command == BUS_LOAD) &&
                (bus.mem2proc_response != 4'd0);
    comp_hit  = (bus.mem2proc_tag != 4'd0) && entry_valid[bus.mem2proc_tag];
    comp_miss = (bus.mem2proc_tag != 4'd0) && !entry_valid[bus.mem2proc_tag];
    count_inc = alloc_en &&
                (!entry_valid[bus.mem2proc_response] ||
                 (comp_hit && bus.mem2proc_tag == bus.mem2proc_response));
  end

  // Route a valid completion to its recorded owner; rdata is a plain broadcast
  always_comb begin
    bus.d_tag = 4'd0;
    bus.i_tag = 4'd0;
    bus.p_tag = 4'd0;
    bus.rdata = bus.mem2proc_data;
    if (comp_hit) begin
      case (entry_owner[bus.mem2proc_tag])
        OWN_D:   bus.d_tag = bus.mem2proc_tag;
        OWN_I:   bus.i_tag = bus.mem2proc_tag;
        default: bus.p_tag = bus.mem2proc_tag;
      endcase
    end
  end

  // Valid bits: completion clears first, so a same-tag allocation wins
  always_ff @(posedge clock) begin
    if (reset) begin
      entry_valid <= 16'd0;
    end else begin
      if (comp_hit) entry_valid[bus.mem2proc_tag] <= 1'b0;
      if (alloc_en) entry_valid[bus.mem2proc_response] <= 1'b1;
    end
  end

  // Owner field only matters while valid, so it needs no reset
  always_ff @(posedge clock) begin
    if (alloc_en) entry_owner[bus.mem2proc_response] <= grant_owner;
  end

  // In-flight load count tracks the number of valid table entries
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.outstanding <= 5'd0;
    end else if (count_inc && !comp_hit) begin
      bus.outstanding <= bus.outstanding + 5'd1;
    end else if (comp_hit && !count_inc) begin
      bus.outstanding <= bus.outstanding - 5'd1;
    end
  end

  // Sticky flag for completions that match no recorded load
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.tag_err <= 1'b0;
    end else if (comp_miss) begin
      bus.tag_err <= 1'b1;
    end
  end

endmodule
